// File: rtl/gpr_access_arbiter_pkg.sv
// Shared types and constants for the general-purpose register file access path.
package gpr_access_arbiter_pkg;

    localparam int unsigned GPR_NUM   = 8;
    localparam int unsigned GPR_W     = 8;
    localparam int unsigned GPR_SEL_W = 3;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } gpr_op_e;

    typedef struct packed {
        gpr_op_e                op;
        logic [GPR_SEL_W-1:0]   reg_num;
        logic [GPR_W-1:0]       wdata;
    } gpr_req_t;

    // Assemble one requester's flattened port slices into a request record.
    function automatic gpr_req_t pack_req(
        input logic                 write,
        input logic [GPR_SEL_W-1:0] reg_num,
        input logic [GPR_W-1:0]     wdata
    );
        gpr_req_t r;
        r.op      = gpr_op_e'(write);
        r.reg_num = reg_num;
        r.wdata   = wdata;
        return r;
    endfunction

endpackage

// File: rtl/gpr_access_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: grants the first valid requester above ptr (mod NREQ).
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    logic [IDW-1:0] cand;

    // Search starts one past the last winner so the last winner has lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!any_grant && valid[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/gpr_access_arbiter.sv
// Shares the single-port GPR file between NREQ requesters and routes read data back.
module gpr_access_arbiter
    import gpr_access_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_write,
    input  logic [GPR_SEL_W*NREQ-1:0] req_reg,
    input  logic [GPR_W*NREQ-1:0]     req_wdata,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           resp_valid,
    output logic [GPR_W-1:0]          resp_rdata,
    output logic                      gpr_read_en,
    output logic                      gpr_write_en,
    output logic [GPR_SEL_W-1:0]      gpr_reg_num,
    output logic [GPR_W-1:0]          gpr_write_data,
    input  logic [GPR_W-1:0]          gpr_read_data
);

    logic [NREQ-1:0] arb_valid;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any_grant;

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            resp_vld_q, resp_vld_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;

    gpr_req_t        req_a [NREQ];
    gpr_req_t        req_sel;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_a[i] = pack_req(req_write[i],
                                req_reg[GPR_SEL_W*i +: GPR_SEL_W],
                                req_wdata[GPR_W*i +: GPR_W]);
        end
    end

    // Holding valids off during reset keeps every grant-derived output quiet.
    assign arb_valid = req_valid & {NREQ{rst_n}};

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .valid     (arb_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Register file port driven straight from the winning request.
    always_comb begin
        req_ready      = grant;
        req_sel        = req_a[grant_idx];
        gpr_read_en    = 1'b0;
        gpr_write_en   = 1'b0;
        gpr_reg_num    = '0;
        gpr_write_data = '0;
        if (any_grant) begin
            gpr_read_en    = (req_sel.op == OP_READ);
            gpr_write_en   = (req_sel.op == OP_WRITE);
            gpr_reg_num    = req_sel.reg_num;
            gpr_write_data = req_sel.wdata;
        end
    end

    always_comb begin
        rr_ptr_d   = any_grant ? grant_idx : rr_ptr_q;
        resp_vld_d = gpr_read_en;
        resp_id_d  = grant_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= IDW'(NREQ - 1);
            resp_vld_q <= 1'b0;
            resp_id_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            resp_vld_q <= resp_vld_d;
            resp_id_q  <= resp_id_d;
        end
    end

    // Read data arrives from the register file one cycle after the grant.
    always_comb begin
        resp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (resp_vld_q && (resp_id_q == IDW'(i))) begin
                resp_valid[i] = 1'b1;
            end
        end
        resp_rdata = resp_vld_q ? gpr_read_data : '0;
    end

endmodule

// File: tb/tb_gpr_access_arbiter.sv
// Self-checking bench for gpr_access_arbiter with a behavioural 8x8 register file.
module tb_gpr_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [5:0]  req_reg = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_rdata;
    logic        gpr_read_en;
    logic        gpr_write_en;
    logic [2:0]  gpr_reg_num;
    logic [7:0]  gpr_write_data;
    logic [7:0]  gpr_read_data = '0;

    int checks = 0;
    int errors = 0;
    int tb_ptr = 1;

    logic [7:0] mem [8];
    logic [7:0] ref_mem [8];

    typedef struct {
        logic [1:0] vld;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q [$];

    typedef struct {
        logic [1:0] v;
        logic [1:0] w;
        logic [2:0] r0;
        logic [2:0] r1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] rdy;
    } vec_t;
    vec_t tbl [15];

    always #5 clk = ~clk;

    gpr_access_arbiter #(.NREQ(2), .IDW(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_reg        (req_reg),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .gpr_read_en    (gpr_read_en),
        .gpr_write_en   (gpr_write_en),
        .gpr_reg_num    (gpr_reg_num),
        .gpr_write_data (gpr_write_data),
        .gpr_read_data  (gpr_read_data)
    );

    // Register file model: registered read output, write at the edge.
    always @(posedge clk) begin
        if (gpr_write_en) mem[gpr_reg_num] <= gpr_write_data;
        if (gpr_read_en) gpr_read_data <= mem[gpr_reg_num];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] rr_exp(input logic [1:0] v, input int p);
        if (p == 1) return v[0] ? 2'b01 : (v[1] ? 2'b10 : 2'b00);
        else        return v[1] ? 2'b10 : (v[0] ? 2'b01 : 2'b00);
    endfunction

    // One cycle: drive after negedge, check the port mid-cycle, check responses after the edge.
    task automatic cycle(input logic [1:0] v, input logic [1:0] w,
                         input logic [2:0] r0, input logic [2:0] r1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] exp_rdy);
        logic [12:0] exp_bus;
        logic        g;
        exp_t        e;
        req_valid = v;
        req_write = w;
        req_reg   = {r1, r0};
        req_wdata = {d1, d0};
        #1;
        chk("ready", 32'(req_ready), 32'(exp_rdy));
        g = exp_rdy[1];
        exp_bus = '0;
        if (exp_rdy != 2'b00)
            exp_bus = {~w[g], w[g], (g ? r1 : r0), (g ? d1 : d0)};
        chk("gpr_port", 32'({gpr_read_en, gpr_write_en, gpr_reg_num, gpr_write_data}), 32'(exp_bus));
        chk("rd_wr_excl", 32'(gpr_read_en & gpr_write_en), 32'd0);
        if (exp_rdy != 2'b00) begin
            if (!w[g]) begin
                e.vld  = exp_rdy;
                e.data = ref_mem[g ? r1 : r0];
                sb_q.push_back(e);
            end else begin
                ref_mem[g ? r1 : r0] = g ? d1 : d0;
            end
            tb_ptr = int'(g);
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("resp", 32'({resp_valid, resp_rdata}), 32'({e.vld, e.data}));
        end else begin
            chk("resp_idle", 32'({resp_valid, resp_rdata}), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 8'h40 + 8'(i);
            ref_mem[i] = 8'h40 + 8'(i);
        end
        mem[3] = 8'h11; ref_mem[3] = 8'h11;
        mem[5] = 8'h22; ref_mem[5] = 8'h22;

        tbl[0]  = '{2'b11, 2'b00, 3'd3, 3'd5, 8'h00, 8'h00, 2'b01};
        tbl[1]  = '{2'b10, 2'b00, 3'd3, 3'd5, 8'h00, 8'h00, 2'b10};
        tbl[2]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00};
        tbl[3]  = '{2'b01, 2'b01, 3'd2, 3'd0, 8'hA5, 8'h00, 2'b01};
        tbl[4]  = '{2'b10, 2'b00, 3'd0, 3'd2, 8'h00, 8'h00, 2'b10};
        tbl[5]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00};
        tbl[6]  = '{2'b01, 2'b00, 3'd7, 3'd0, 8'h00, 8'h00, 2'b01};
        for (int i = 7; i < 12; i++)
            tbl[i] = '{2'b00, 2'b11, 3'd1, 3'd2, 8'h5A, 8'h3C, 2'b00};
        tbl[12] = '{2'b10, 2'b00, 3'd0, 3'd4, 8'h00, 8'h00, 2'b10};
        tbl[13] = '{2'b11, 2'b00, 3'd6, 3'd1, 8'h00, 8'h00, 2'b01};
        tbl[14] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00};

        // Reset: everything quiet even with requests pending.
        req_valid = 2'b11;
        req_reg   = {3'd5, 3'd3};
        #3;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_gpr_port", 32'({gpr_read_en, gpr_write_en, gpr_reg_num, gpr_write_data}), 32'd0);
        chk("rst_resp", 32'({resp_valid, resp_rdata}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        tb_ptr = 1;

        foreach (tbl[i])
            cycle(tbl[i].v, tbl[i].w, tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, tbl[i].rdy);

        // Fairness: both requesters continuously valid alternate.
        for (int i = 0; i < 10; i++)
            cycle(2'b11, 2'b00, 3'(i), 3'(i + 3), 8'h00, 8'h00, rr_exp(2'b11, tb_ptr));
        cycle(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);

        // Back-to-back reads from requester 1 alone.
        for (int r = 0; r < 8; r++)
            cycle(2'b10, 2'b00, 3'd0, 3'(r), 8'h00, 8'h00, 2'b10);
        cycle(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);

        // Reset while a read response is in flight.
        req_valid = 2'b01;
        req_write = 2'b00;
        req_reg   = {3'd0, 3'd3};
        #1;
        chk("mid_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("mid_resp_pre", 32'({resp_valid, resp_rdata}), 32'({2'b01, 8'h11}));
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_reg   = {3'd5, 3'd3};
        #1;
        chk("mid_resp_rst", 32'({resp_valid, resp_rdata}), 32'd0);
        chk("mid_ready_rst", 32'(req_ready), 32'd0);
        chk("mid_en_rst", 32'({gpr_read_en, gpr_write_en}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        tb_ptr = 1;
        #1;
        chk("post_rst_resp", 32'(resp_valid), 32'd0);
        cycle(2'b11, 2'b00, 3'd3, 3'd5, 8'h00, 8'h00, 2'b01);
        cycle(2'b10, 2'b00, 3'd3, 3'd5, 8'h00, 8'h00, 2'b10);
        cycle(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_access_arbiter.md
Name: gpr_access_arbiter

Overview:
- Shares the single-port 8x8 general-purpose register file between NREQ requesters, for example fetch/decode and execute.
- Arbitrates round-robin and drives the register file's read_en/write_en/reg_num/write-data port, with at most one operation per cycle.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between the requesting units and the register file; the register file contents are never reset by this block.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 1, requester index width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_write  in  NREQ  per-requester op: 1 = write, 0 = read.
- req_reg  in  3*NREQ  per-requester register number; slice i = [3i+2:3i].
- req_wdata  in  8*NREQ  per-requester write data; slice i = [8i+7:8i].
- req_ready  out  NREQ  one-hot grant; a request transfers when valid & ready.
- resp_valid  out  NREQ  one-hot; read data for requester i is valid this cycle.
- resp_rdata  out  8  read data; qualified by resp_valid.
- gpr_read_en  out  1  to register file read enable.
- gpr_write_en  out  1  to register file write enable.
- gpr_reg_num  out  3  to register file register select.
- gpr_write_data  out  8  to register file write data.
- gpr_read_data  in  8  from register file registered read output.

Behaviour:
- Reset (rst_n low, async):
  - rr_ptr = NREQ-1, so requester 0 wins first.
  - Response pipeline cleared: resp_valid = 0.
  - req_ready = 0, gpr_read_en = 0, gpr_write_en = 0, gpr_reg_num = 0, gpr_write_data = 0.
  - resp_rdata = 0.
- Arbitration (combinational, every cycle):
  - Grant the first requester with req_valid = 1, searching upward from rr_ptr+1 modulo NREQ.
  - req_ready is one-hot or all-zero; a ready is never asserted without its valid.
- Pointer update: on a cycle with any grant, rr_ptr <= granted index; otherwise rr_ptr holds.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- Register file drive (combinational from the grant):
  - gpr_read_en = grant & ~req_write[g].
  - gpr_write_en = grant & req_write[g].
  - gpr_reg_num = req_reg[g]; gpr_write_data = req_wdata[g].
  - With no grant, both enables are 0 and gpr_reg_num/gpr_write_data are 0.
  - read_en and write_en are never high together.
- Writes: complete at the grant edge, with no response. A read granted in the next cycle to the same register returns the new value.
- Reads, issued in cycle T:
  - Capture the id into the response stage at the T edge.
  - In T+1: resp_valid[id] = 1 and resp_rdata = gpr_read_data, which is valid after the T edge.
  - Latency is 1 cycle; back-to-back reads pipeline at 1 per cycle.
  - resp_rdata is combinational pass-through when resp_valid is high, and 0 otherwise.
- No response backpressure: requesters must accept resp_valid in the cycle it is high.
- Requester obligation: hold req_valid/req_write/req_reg/req_wdata stable until ready. The arbiter does not check this.
- Reset mid-operation: an in-flight read response is dropped, resp_valid = 0 at the cycle after reset release, and the pointer restarts.
- Corner cases:
  - A requester may issue a new request in the same cycle its previous read response returns.
  - A single requester that is always valid is granted every cycle.

Decomposition:
- Shared package:
  - GPR_NUM = 8, GPR_W = 8, GPR_SEL_W = 3.
  - Op encoding OP_READ = 0, OP_WRITE = 1.
  - A request struct/typedef {write, reg, wdata}.
- One natural sub-module: rr_arbiter (parameterised NREQ).
  - Inputs: valid vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Reusable for other shared resources.
- Response pipeline and register-file muxing stay in gpr_access_arbiter.

Test Plan:
1. Reset and first grants: reset, then both requesters valid reading R3 and R5 (GPR preloaded 0x11/0x22), requester 0 granted first.
   - Cycle 1: resp_valid = 01, rdata = 0x11.
   - Cycle 2: resp_valid = 10, rdata = 0x22.
2. Write-then-read: req0 writes R2 = 0xA5, next cycle req1 reads R2 -> resp_valid[1] one cycle after its grant with rdata = 0xA5. gpr_read_en and gpr_write_en are never high together.
3. Fairness: both valid for 10 cycles -> grants alternate 0,1,0,1…; req_ready is always one-hot.
4. Back-to-back: req1 alone reads R0..R7 over 8 consecutive cycles -> 8 consecutive resp_valid = 10 cycles, rdata matching each register in order.
5. Reset mid-read: assert rst_n low in the cycle after a read grant -> resp_valid = 0 and all GPR enables = 0 immediately; after release, requester 0 is granted first.
6. Idle: no valid for 5 cycles -> req_ready = 0, gpr_read_en = gpr_write_en = 0, pointer unchanged; a later single req1 is granted immediately.
